cmn_fifo_unpack: RTL
====================

CMN_FIFO_UNPACK -- requirements
Module: cmn_fifo_unpack

Interface
REQ-001 The block SHALL have parameter IW, default 32, meaning FIFO word width in bits.
REQ-002 The block SHALL have parameter OW, default 8, meaning output beat width in bits; IW SHALL be an integer multiple of OW, with RATIO = IW/OW >= 1.
REQ-003 The block SHALL have parameter LSB_FIRST, default 1, meaning 1 = emit slice [OW-1:0] first, 0 = emit the most-significant slice first.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-007 The block SHALL have port fifo_re, output, 1 bit: upstream FIFO pop strobe.
REQ-008 The block SHALL have port fifo_rdata, input, IW bits: FIFO head word, valid in the same cycle whenever fifo_empty=0 (unregistered read).
REQ-009 The block SHALL have port flush, input, 1 bit: synchronous discard of the word being unpacked.
REQ-010 The block SHALL have port out_valid, output, 1 bit: beat available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the beat.
REQ-012 The block SHALL have port out_data, output, OW bits: current slice.
REQ-013 The block SHALL have port out_last, output, 1 bit: the current beat is the final slice of its word.

Function
REQ-014 The block SHALL hold one IW-bit word register, a slice counter cnt of width max(1,clog2(RATIO)), and a two-state FSM {EMPTY, ACTIVE}.
REQ-015 The block SHALL drive out_valid=1 exactly when the state is ACTIVE; out_data and out_last SHALL come from registers and the cnt mux only, with no combinational path from any input.
REQ-016 The block SHALL select slice index cnt for out_data when LSB_FIRST=1, and slice RATIO-1-cnt when LSB_FIRST=0; out_last SHALL equal (cnt == RATIO-1).
REQ-017 In EMPTY with fifo_empty=0 and flush=0, the block SHALL assert fifo_re, capture fifo_rdata, set cnt=0, and go to ACTIVE.
REQ-018 In ACTIVE with out_valid && out_ready and cnt < RATIO-1, the block SHALL increment cnt.
REQ-019 In ACTIVE with out_valid && out_ready and cnt == RATIO-1:
  - fifo_empty=0: assert fifo_re, load the new word, set cnt=0, stay in ACTIVE (no bubble).
  - fifo_empty=1: go to EMPTY.
REQ-020 In ACTIVE with out_ready=0, the block SHALL hold out_data, out_last, cnt and the word register stable, with fifo_re=0.
REQ-021 The block SHALL never assert fifo_re while fifo_empty=1, while flush=1, or while rstn=0.
REQ-022 fifo_re SHALL be at most one cycle per word, and the number of fifo_re pulses SHALL equal the number of words whose out_last beat is handshaken or flushed.
REQ-023 Latency: when fifo_empty falls in cycle t with the state EMPTY, out_valid SHALL rise in cycle t+1.
REQ-024 Throughput: with out_ready held at 1 and the FIFO non-empty, the block SHALL emit one beat per cycle indefinitely.
REQ-025 flush=1 SHALL move the state to EMPTY and set cnt=0 at the next edge, regardless of out_ready; a handshake in the same cycle SHALL still count as consumed; flush SHALL take priority over all loads.
REQ-026 For RATIO=1, the block SHALL hold cnt at 0, keep out_last at 1, and load one word per handshake.

Reset
REQ-027 While rstn=0, the block SHALL force the state to EMPTY, cnt=0, word register=0, out_valid=0, out_data=0, out_last=0 (RATIO>1) and fifo_re=0.
REQ-028 Assertion of rstn mid-word SHALL discard the partial word; the first beat after release SHALL be slice 0 of the next FIFO word.

Verification (IW=32, OW=8 unless stated)
REQ-029 The bench SHALL cover: reset with fifo_empty=0 -> fifo_re=0 and out_valid=0 throughout reset; fifo_re=1 on the first cycle after release.
REQ-030 The bench SHALL cover: one word 0x44332211, out_ready=1 -> single fifo_re pulse, then out_data 11,22,33,44 on 4 consecutive cycles, out_last only on 44, then out_valid=0.
REQ-031 The bench SHALL cover: words 0x44332211 and 0x88776655 queued, out_ready=1 -> 8 consecutive beats 11..88; the second fifo_re is coincident with the 44 handshake.
REQ-032 The bench SHALL cover: out_ready=0 for 3 cycles while 0x22 is presented -> out_data stays 0x22, out_valid=1, fifo_re=0; resume gives 33,44.
REQ-033 The bench SHALL cover: flush during beat 0x33 -> out_valid=0 next cycle, no fifo_re that cycle; next word 0xDDCCBBAA yields AA,BB,CC,DD.
REQ-034 The bench SHALL cover: LSB_FIRST=0 with word 0x44332211 -> beats 44,33,22,11, and RATIO=1 (OW=32) with 0xCAFEF00D -> one beat with out_last=1.

Source files
------------

// File: rtl/cmn_fifo_unpack.sv
// cmn_fifo_unpack: pops IW-bit words from an upstream FIFO and streams them
// out as RATIO = IW/OW beats of OW bits with valid/ready handshaking.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// S_EMPTY  | no word held; pops the FIFO head as soon as one is available
// S_ACTIVE | word held; beat cnt is presented on out_data
module cmn_fifo_unpack #(
  parameter int IW        = 32,
  parameter int OW        = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [IW-1:0] fifo_rdata,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last
);

  localparam int RATIO = IW / OW;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  typedef enum logic {
    S_EMPTY  = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] word_q, word_d;
  logic          hs;
  logic [CW-1:0] sel;

  // State, slice counter and word register; reset clears everything so
  // a word interrupted by reset is discarded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Next state: flush beats any load, a pop reloads the word (also back to
  // back on the last beat), otherwise a handshake advances the slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (flush) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
    end else if (fifo_re) begin
      state_d = S_ACTIVE;
      cnt_d   = '0;
      word_d  = fifo_rdata;
    end else if (hs) begin
      if (out_last) begin
        state_d = S_EMPTY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Outputs: beat data/last depend only on registers; the pop strobe is
  // gated by reset so an early non-empty FIFO is never popped during reset.
  always_comb begin
    out_valid = (state_q == S_ACTIVE);
    out_last  = (cnt_q == CNT_LAST);
    hs        = out_valid && out_ready;
    fifo_re   = rstn && !flush && !fifo_empty &&
                ((state_q == S_EMPTY) || (hs && out_last));
    sel       = (LSB_FIRST != 0) ? cnt_q : (CNT_LAST - cnt_q);
    out_data  = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel == CW'(i)) out_data = word_q[i*OW +: OW];
    end
  end

endmodule
